// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter sharing one host SD block channel between NREQ track loaders.
// Each grant carries one whole rd/wr burst; a watchdog aborts a strobe the host never acknowledges.
module ieeedrv_sd_arb #(
    parameter int NREQ      = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [32*NREQ-1:0]   req_lba,
    input  logic [6*NREQ-1:0]    req_blk_cnt,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    output logic [NREQ-1:0]      req_ack,
    input  logic [8*NREQ-1:0]    req_buff_din,
    output logic [NREQ-1:0]      req_buff_wr,
    output logic [31:0]          sd_lba,
    output logic [5:0]           sd_blk_cnt,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_buff_din,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned N        = NREQ;
    localparam int          CW       = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam logic        WD_EN    = (TIMEOUT_W > 0);
    // Abort when the increment would reach all-ones, so the strobe lasts 2^W-1 cycles.
    localparam logic [CW-1:0] WD_LAST = ~CW'(1);
    localparam logic [1:0]  GRANT_RST = 2'(NREQ - 1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_GAP
    } state_t;

    state_t         state, state_n;
    logic [1:0]     grant_n;
    logic [31:0]    lba_n;
    logic [5:0]     blk_n;
    logic           rd_n, wr_n, timeout_n;
    logic [CW-1:0]  wd, wd_n;

    logic           found;
    logic [1:0]     win;
    logic           win_rd, win_wr;
    logic [31:0]    win_lba;
    logic [5:0]     win_blk;

    // Round-robin search starting just after the last grant.
    always_comb begin
        found = 1'b0;
        win   = grant;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (i == ((32'(grant) + k) % N)) && (req_rd[i] || req_wr[i])) begin
                    found = 1'b1;
                    win   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        win_rd  = 1'b0;
        win_wr  = 1'b0;
        win_lba = '0;
        win_blk = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win == 2'(i)) begin
                win_rd  = req_rd[i];
                win_wr  = req_wr[i];
                win_lba = req_lba[32*i +: 32];
                win_blk = req_blk_cnt[6*i +: 6];
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        lba_n     = sd_lba;
        blk_n     = sd_blk_cnt;
        rd_n      = sd_rd;
        wr_n      = sd_wr;
        wd_n      = wd;
        timeout_n = 1'b0;
        case (state)
            S_DRAIN: begin
                if (!sd_ack) state_n = S_IDLE;
            end
            S_IDLE: begin
                if (found) begin
                    grant_n = win;
                    lba_n   = win_lba;
                    blk_n   = win_blk;
                    wr_n    = win_wr;
                    rd_n    = win_rd & ~win_wr;
                    wd_n    = '0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sd_ack) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = S_XFER;
                end else if (WD_EN && (wd == WD_LAST)) begin
                    rd_n      = 1'b0;
                    wr_n      = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = S_DRAIN;
                end else if (WD_EN) begin
                    wd_n = wd + CW'(1);
                end
            end
            S_XFER: begin
                if (!sd_ack) state_n = S_GAP;
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: state_n = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_DRAIN;
            grant      <= GRANT_RST;
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            wd         <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            sd_lba     <= lba_n;
            sd_blk_cnt <= blk_n;
            sd_rd      <= rd_n;
            sd_wr      <= wr_n;
            wd         <= wd_n;
            timeout    <= timeout_n;
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        sd_buff_din = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == 2'(i)) begin
                req_ack[i]     = sd_ack & ((state == S_ISSUE) || (state == S_XFER));
                req_buff_wr[i] = sd_buff_wr & ((state == S_ISSUE) || (state == S_XFER));
                sd_buff_din    = req_buff_din[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Bench for ieeedrv_sd_arb: two requesters, short watchdog, host modelled procedurally.
// Expected grants are queued when requests are raised and compared when the strobe rises.
module tb_ieeedrv_sd_arb;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [63:0] req_lba;
    logic [11:0] req_blk_cnt;
    logic [1:0]  req_rd, req_wr;
    logic [1:0]  req_ack;
    logic [15:0] req_buff_din;
    logic [1:0]  req_buff_wr;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr;
    logic        sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [1:0]  grant;
    logic        busy, timeout;

    ieeedrv_sd_arb #(.NREQ(2), .TIMEOUT_W(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_lba(req_lba), .req_blk_cnt(req_blk_cnt),
        .req_rd(req_rd), .req_wr(req_wr), .req_ack(req_ack),
        .req_buff_din(req_buff_din), .req_buff_wr(req_buff_wr),
        .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          who;
        logic [31:0] lba;
        logic [5:0]  blk;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic prev_strobe = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [31:0] lba, input logic [5:0] blk,
                           input logic rd, input logic wr);
        req_lba[32*who +: 32]  = lba;
        req_blk_cnt[6*who +: 6] = blk;
        req_rd[who] = rd;
        req_wr[who] = wr;
    endtask

    task automatic push_exp(input int who, input logic [31:0] lba, input logic [5:0] blk, input logic wr);
        exp_t e;
        e.who = who; e.lba = lba; e.blk = blk; e.wr = wr;
        sb.push_back(e);
    endtask

    // Scoreboard: every rising host strobe must match the oldest expected grant.
    always @(negedge clk_sys) begin
        logic strobe;
        exp_t e;
        strobe = sd_rd | sd_wr;
        if (strobe && !prev_strobe) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 64'(grant), 64'hff);
            end else begin
                e = sb.pop_front();
                check("sb_grant", 64'(grant), 64'(e.who));
                check("sb_lba", 64'(sd_lba), 64'(e.lba));
                check("sb_blk", 64'(sd_blk_cnt), 64'(e.blk));
                check("sb_wr", 64'(sd_wr), 64'(e.wr));
                check("sb_rd", 64'(sd_rd), 64'(!e.wr));
            end
        end
        prev_strobe = strobe;
    end

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("strobe_wait", 64'd0, 64'd1);
    endtask

    // Host side of one burst: ack, buffer pulses, release, then requester drops its request.
    task automatic host_serve(input int who, input int len);
        bit         ok;
        logic [1:0] mask;
        mask = 2'(1 << who);
        wait_strobe(ok);
        if (ok) begin
            @(posedge clk_sys); #1;
            sd_ack = 1'b1;
            @(negedge clk_sys);
            check("ack_issue", 64'(req_ack), 64'(mask));
            for (int i = 0; i < len; i++) begin
                @(posedge clk_sys); #1;
                sd_buff_wr = (i % 2) == 0;
                @(negedge clk_sys);
                check("ack_xfer", 64'(req_ack), 64'(mask));
                check("buff_wr", 64'(req_buff_wr), 64'(sd_buff_wr ? mask : 2'b00));
                check("strobe_off", 64'(sd_rd | sd_wr), 64'd0);
            end
            @(posedge clk_sys); #1;
            sd_buff_wr = 1'b0;
            sd_ack     = 1'b0;
            @(posedge clk_sys); #1;
            req_rd[who] = 1'b0;
            req_wr[who] = 1'b0;
            @(negedge clk_sys);
            check("ack_gap", 64'(req_ack), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit ok;
        int n;
        reset        = 1'b1;
        req_lba      = '0;
        req_blk_cnt  = '0;
        req_rd       = '0;
        req_wr       = '0;
        req_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;

        // Test 1: reset values, then one-cycle latency from IDLE to strobe.
        set_req(0, 32'd29, 6'd3, 1'b1, 1'b0);
        push_exp(0, 32'd29, 6'd3, 1'b0);
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_rd", 64'(sd_rd), 64'd0);
        check("rst_wr", 64'(sd_wr), 64'd0);
        check("rst_lba", 64'(sd_lba), 64'd0);
        check("rst_blk", 64'(sd_blk_cnt), 64'd0);
        check("rst_grant", 64'(grant), 64'd1);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check("drain_busy", 64'(busy), 64'd1);
        @(negedge clk_sys);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_rd", 64'(sd_rd), 64'd0);
        @(negedge clk_sys);
        check("lat_rd", 64'(sd_rd), 64'd1);
        check("lat_lba", 64'(sd_lba), 64'd29);
        host_serve(0, 10);

        // Test 4: requester 1 alone; buffer data mux and mid-burst LBA change.
        req_buff_din = {8'hA5, 8'h00};
        set_req(1, 32'h0001_2345, 6'd17, 1'b1, 1'b0);
        push_exp(1, 32'h0001_2345, 6'd17, 1'b0);
        wait_strobe(ok);
        check("buff_din", 64'(sd_buff_din), 64'hA5);
        req_lba[63:32] = 32'hDEAD_BEEF;
        @(negedge clk_sys);
        check("lba_hold", 64'(sd_lba), 64'h0001_2345);
        host_serve(1, 4);

        // Test 2: simultaneous reads; last grant was 1 so requester 0 goes first.
        req_buff_din = '0;
        set_req(0, 32'd100, 6'd5, 1'b1, 1'b0);
        set_req(1, 32'd200, 6'd9, 1'b1, 1'b0);
        push_exp(0, 32'd100, 6'd5, 1'b0);
        push_exp(1, 32'd200, 6'd9, 1'b0);
        host_serve(0, 10);
        host_serve(1, 10);

        // Test 3: read and write together, write wins; buffer strobes only reach requester 0.
        set_req(0, 32'd777, 6'd63, 1'b1, 1'b1);
        push_exp(0, 32'd777, 6'd63, 1'b1);
        host_serve(0, 6);

        // Test 5: no host ack; watchdog drops the strobe after 15 cycles, then re-issues.
        set_req(1, 32'd4242, 6'd2, 1'b1, 1'b0);
        push_exp(1, 32'd4242, 6'd2, 1'b0);
        push_exp(1, 32'd4242, 6'd2, 1'b0);
        wait_strobe(ok);
        n = ok ? 1 : 0;
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge clk_sys);
            if (sd_rd) n++;
            else break;
        end
        check("wd_len", 64'(n), 64'd15);
        check("wd_pulse", 64'(timeout), 64'd1);
        check("wd_rd_off", 64'(sd_rd), 64'd0);
        @(negedge clk_sys);
        check("wd_pulse_end", 64'(timeout), 64'd0);
        host_serve(1, 4);

        // Test 6: reset during XFER with ack high; must stay drained until ack drops.
        set_req(0, 32'd55, 6'd1, 1'b1, 1'b0);
        push_exp(0, 32'd55, 6'd1, 1'b0);
        wait_strobe(ok);
        @(posedge clk_sys); #1;
        sd_ack = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check("rx_rd", 64'(sd_rd | sd_wr), 64'd0);
        check("rx_busy", 64'(busy), 64'd1);
        check("rx_grant", 64'(grant), 64'd1);
        check("rx_lba", 64'(sd_lba), 64'd0);
        check("rx_ack", 64'(req_ack), 64'd0);
        push_exp(0, 32'd55, 6'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check("rx_hold", 64'({busy, sd_rd}), 64'b10);
        end
        @(posedge clk_sys); #1;
        sd_ack = 1'b0;
        host_serve(0, 3);

        repeat (3) @(negedge clk_sys);
        check("sb_left", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
